// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the core memory stage and an external loader/debug port.
// Build option: define DMEM_ARB_RR_EN for round-robin conflict resolution (default: fixed priority with starvation limit).
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_en,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic             conflict;
    logic             ext_pri;
    logic             core_win;
    logic             ext_win;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic [1:0]       tag;
    logic [1:0]       tag_nxt;

`ifdef DMEM_ARB_RR_EN
    // last_owner: 0 = core, 1 = ext; the other side wins the next conflict
    logic last_owner;

    always_comb begin
        ext_pri = ~last_owner;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= 1'b0;
        end else if (conflict) begin
            last_owner <= ext_win;
        end
    end

    always_comb begin
        wait_cnt_nxt = '0;
    end
`else
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    always_comb begin
        ext_pri = (wait_cnt == WAIT_MAX);
    end

    // Count consecutive denied ext cycles, saturating at the starvation limit
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!ext_req || ext_win) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end
`endif

    // Same-cycle grant decision
    always_comb begin
        conflict   = core_en & ext_req;
        ext_win    = ext_req & (~core_en | ext_pri);
        core_win   = core_en & ~ext_win;
        core_stall = core_en & ~core_win;
        ext_gnt    = ext_win;
    end

    // Winner drives the RAM port; idle port is fully zeroed
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (core_win) begin
            ram_en   = 1'b1;
            ram_we   = core_we;
            ram_addr = core_addr;
            ram_din  = core_wdata;
        end else if (ext_win) begin
            ram_en   = 1'b1;
            ram_we   = ext_we;
            ram_addr = ext_addr;
            ram_din  = ext_wdata;
        end
    end

    always_comb begin
        tag_nxt = {core_win & ~core_we, ext_win & ~ext_we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            tag      <= 2'b00;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            tag      <= tag_nxt;
        end
    end

    // Read data is steered to whichever owner issued last cycle's read
    always_comb begin
        core_rvalid = tag[1];
        ext_rvalid  = tag[0];
        core_rdata  = tag[1] ? ram_dout : '0;
        ext_rdata   = tag[0] ? ram_dout : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 1-cycle-latency RAM model.
// Round-robin checks are compiled in when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_en, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              ext_req, ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt, ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .core_rvalid(core_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rdata  (ext_rdata),
        .ext_rvalid (ext_rvalid),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        core_en = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic core_rd(input logic [ADDR_W-1:0] a);
        core_en = 1'b1; core_we = 1'b0; core_addr = a; core_wdata = '0;
    endtask

    task automatic ext_rd(input logic [ADDR_W-1:0] a);
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = a; ext_wdata = '0;
    endtask

    // One uncontended ext write cycle, used for preload
    task automatic ext_wr_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        idle();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        #1;
        check("preload_gnt", 32'(ext_gnt), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        check("rst_ext_rvalid",  32'(ext_rvalid),  32'd0);
        check("rst_core_rdata",  core_rdata,       32'd0);
        check("rst_ext_rdata",   ext_rdata,        32'd0);
        check("rst_wait_cnt",    32'(dut.wait_cnt), 32'd0);
        #1;
        check("idle_ram_en",   32'(ram_en),   32'd0);
        check("idle_ram_addr", 32'(ram_addr), 32'd0);

        ext_wr_cycle(10'h010, 32'hDEADBEEF);
        ext_wr_cycle(10'h040, 32'h11111111);
        ext_wr_cycle(10'h050, 32'h22222222);

        // Core load alone
        @(negedge clk);
        idle(); core_rd(10'h010);
        #1;
        check("ld_ram_en",     32'(ram_en),     32'd1);
        check("ld_ram_addr",   32'(ram_addr),   32'h010);
        check("ld_ram_we",     32'(ram_we),     32'd0);
        check("ld_core_stall", 32'(core_stall), 32'd0);
        @(negedge clk);
        check("ld_core_rvalid", 32'(core_rvalid), 32'd1);
        check("ld_core_rdata",  core_rdata,       32'hDEADBEEF);
        check("ld_ext_rvalid",  32'(ext_rvalid),  32'd0);
        check("ld_ext_rdata",   ext_rdata,        32'd0);

        // Ext write then core load of same address
        idle();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 10'h020; ext_wdata = 32'h12345678;
        #1;
        check("ewr_gnt",     32'(ext_gnt),  32'd1);
        check("ewr_ram_we",  32'(ram_we),   32'd1);
        check("ewr_ram_din", ram_din,       32'h12345678);
        @(negedge clk);
        check("ewr_no_ext_rvalid",  32'(ext_rvalid),  32'd0);
        check("ewr_no_core_rvalid", 32'(core_rvalid), 32'd0);
        idle(); core_rd(10'h020);
        @(negedge clk);
        check("ewr_ld_rvalid", 32'(core_rvalid), 32'd1);
        check("ewr_ld_rdata",  core_rdata,       32'h12345678);

        // Core store, then ext readback
        idle();
        core_en = 1'b1; core_we = 1'b1; core_addr = 10'h030; core_wdata = 32'hA5A50030;
        #1;
        check("cst_ram_we",    32'(ram_we),     32'd1);
        check("cst_ram_din",   ram_din,         32'hA5A50030);
        check("cst_ram_addr",  32'(ram_addr),   32'h030);
        check("cst_stall",     32'(core_stall), 32'd0);
        @(negedge clk);
        check("cst_no_rvalid", 32'(core_rvalid), 32'd0);
        idle(); ext_rd(10'h030);
        #1;
        check("erd_gnt", 32'(ext_gnt), 32'd1);
        @(negedge clk);
        check("erd_rvalid",      32'(ext_rvalid), 32'd1);
        check("erd_rdata",       ext_rdata,       32'hA5A50030);
        check("erd_core_rdata",  core_rdata,      32'd0);

        // Alternating owners, no bubble
        idle(); core_rd(10'h040);
        @(negedge clk);
        idle(); ext_rd(10'h050);
        check("alt_core_rvalid", 32'(core_rvalid), 32'd1);
        check("alt_core_rdata",  core_rdata,       32'h11111111);
        @(negedge clk);
        idle();
        check("alt_ext_rvalid",  32'(ext_rvalid),  32'd1);
        check("alt_ext_rdata",   ext_rdata,        32'h22222222);
        check("alt_core_idle",   32'(core_rvalid), 32'd0);

`ifndef DMEM_ARB_RR_EN
        // Starvation limit: core wins 4 conflicts, ext wins the 5th
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) begin
                check("fp_core_rvalid", 32'(core_rvalid), 32'd1);
                check("fp_core_rdata",  core_rdata,       32'h11111111);
            end
            check("fp_wait_cnt", 32'(dut.wait_cnt), 32'(i));
            idle(); core_rd(10'h040); ext_rd(10'h050);
            #1;
            check("fp_ext_gnt",    32'(ext_gnt),    (i == 4) ? 32'd1 : 32'd0);
            check("fp_core_stall", 32'(core_stall), (i == 4) ? 32'd1 : 32'd0);
            check("fp_ram_addr",   32'(ram_addr),   (i == 4) ? 32'h050 : 32'h040);
        end
        @(negedge clk);
        check("fp_ext_rvalid",  32'(ext_rvalid),  32'd1);
        check("fp_ext_rdata",   ext_rdata,        32'h22222222);
        check("fp_core_none",   32'(core_rvalid), 32'd0);
        check("fp_wait_clear",  32'(dut.wait_cnt), 32'd0);

        // Dropping ext_req clears the count
        idle(); core_rd(10'h040); ext_rd(10'h050);
        @(negedge clk);
        @(negedge clk);
        check("drop_wait_2", 32'(dut.wait_cnt), 32'd2);
        idle(); core_rd(10'h040);
        @(negedge clk);
        check("drop_wait_0", 32'(dut.wait_cnt), 32'd0);
`endif

        // Reset during a contended read and during a granted ext read
        idle(); core_rd(10'h040); ext_rd(10'h050);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_comb_ram_en", 32'(ram_en), 32'd1);
        @(negedge clk);
        check("rst_core_norv",  32'(core_rvalid), 32'd0);
        check("rst_wait_zero",  32'(dut.wait_cnt), 32'd0);
        idle(); ext_rd(10'h050);
        #1;
        check("rst_ext_gnt", 32'(ext_gnt), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("rst_ext_norv",  32'(ext_rvalid), 32'd0);
        check("rst_ext_rdata", ext_rdata,       32'd0);
        check("rst_wait_cnt2", 32'(dut.wait_cnt), 32'd0);

`ifdef DMEM_ARB_RR_EN
        // Round-robin: ext first after reset, then alternate
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) begin
                check("rr_ext_rvalid",  32'(ext_rvalid),  (i % 2 == 1) ? 32'd1 : 32'd0);
                check("rr_core_rvalid", 32'(core_rvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_rdata", (i % 2 == 1) ? ext_rdata : core_rdata,
                      (i % 2 == 1) ? 32'h22222222 : 32'h11111111);
            end
            if (i < 4) begin
                idle(); core_rd(10'h040); ext_rd(10'h050);
                #1;
                check("rr_ext_gnt",    32'(ext_gnt),    (i % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_core_stall", 32'(core_stall), (i % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_wait_cnt",   32'(dut.wait_cnt), 32'd0);
            end else begin
                idle();
            end
        end
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning data RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data RAM word width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive denied ext cycles before ext is forced to win (minimum 1).
REQ-004 The block SHALL have port clk, input, 1, clock.
REQ-005 The block SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-006 The block SHALL have ports core_en, input, 1, and core_we, input, 1, meaning memory-stage access enable and write enable.
REQ-007 The block SHALL have ports core_addr, input, ADDR_W, and core_wdata, input, DATA_W, meaning memory-stage address and store data.
REQ-008 The block SHALL have ports core_stall, output, 1, core_rdata, output, DATA_W, and core_rvalid, output, 1, meaning core access denied this cycle, load data, and load data valid.
REQ-009 The block SHALL have ports ext_req, input, 1, ext_we, input, 1, ext_addr, input, ADDR_W, and ext_wdata, input, DATA_W, meaning external (loader/debug) request, write enable, address and write data.
REQ-010 The block SHALL have ports ext_gnt, output, 1, ext_rdata, output, DATA_W, and ext_rvalid, output, 1, meaning ext request accepted this cycle, read data, and read data valid.
REQ-011 The block SHALL have ports ram_en, output, 1, ram_we, output, 1, ram_addr, output, ADDR_W, ram_din, output, DATA_W, and ram_dout, input, DATA_W, meaning the single-port RAM interface with 1-cycle read latency.

Function
REQ-012 Grant SHALL be combinational: the winner's en/we/addr/wdata drive ram_* in the same cycle; with no winner, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-013 With only core_en=1, core SHALL win, core_stall=0.
REQ-014 With only ext_req=1, ext SHALL win, ext_gnt=1.
REQ-015 On conflict (core_en=1 and ext_req=1), core SHALL win unless wait_cnt==MAX_WAIT, in which case ext SHALL win.
REQ-016 core_stall SHALL equal core_en and not core-wins; ext_gnt SHALL equal ext-wins.
REQ-017 ext_req, ext_we, ext_addr and ext_wdata SHALL be held stable by the requester until ext_gnt=1; a request SHALL complete in exactly the cycle ext_gnt=1.
REQ-018 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment each cycle ext_req=1 and ext_gnt=0, saturating at MAX_WAIT, and SHALL clear on ext_gnt=1 or ext_req=0.
REQ-019 A 2-bit response tag register SHALL capture {core-read, ext-read} each cycle, where a read means winner with we=0.
REQ-020 core_rvalid and ext_rvalid SHALL equal the registered tag bits, asserting exactly one cycle after the granted read; writes SHALL produce no rvalid.
REQ-021 core_rdata and ext_rdata SHALL equal ram_dout when their rvalid=1, and 0 otherwise.
REQ-022 Back-to-back reads by alternating owners SHALL each return data in the next cycle with no bubble.
REQ-023 Simultaneous writes to the same address SHALL be resolved by the grant rule alone; the loser's write SHALL be retried by its owner via stall or held request.

Reset
REQ-024 While rst=1 at a clock edge: wait_cnt=0, tag=00, last_owner=core.
REQ-025 Outputs SHALL therefore read core_rvalid=0, ext_rvalid=0, core_rdata=0, ext_rdata=0 in the cycle after reset.
REQ-026 An access granted in the cycle rst is asserted SHALL NOT produce rvalid.
REQ-027 Combinational grant outputs SHALL follow their inputs during reset, and no request SHALL be considered pending across reset.

Configuration
REQ-028 With macro DMEM_ARB_RR_EN defined, conflicts SHALL be resolved round-robin.
REQ-029 In round-robin mode, the winner SHALL be the requester other than last_owner, a register updated on every conflict to that conflict's winner.
REQ-030 In round-robin mode, wait_cnt SHALL be held at 0.
REQ-031 Without DMEM_ARB_RR_EN, the fixed-priority-with-starvation-limit rule of REQ-015 SHALL apply and last_owner SHALL be absent.

Verification
REQ-032 Core load addr 0x010 alone, RAM holds 0xDEADBEEF -> ram_en=1, core_stall=0; next cycle core_rvalid=1, core_rdata=0xDEADBEEF.
REQ-033 Ext write addr 0x020 data 0x12345678 alone, then core load 0x020 -> ext_gnt=1 in write cycle; core_rdata=0x12345678 one cycle after load.
REQ-034 Fixed priority, MAX_WAIT=4, core_en and ext_req held high -> core wins 4 cycles; 5th cycle ext_gnt=1, core_stall=1; wait_cnt then 0.
REQ-035 RR_EN defined, continuous conflict with reads -> grants alternate ext, core, ext, core; matching rvalid pulses one cycle later.
REQ-036 Ext read granted, rst asserted the same cycle -> ext_rvalid=0 next cycle; wait_cnt=0.
REQ-037 Core store 0x030 (core_we=1) -> ram_we=1, ram_din=core_wdata; no rvalid next cycle.
